// File: rtl/rb_commit_controller.sv
// rb_commit_controller: reorder-buffer commit unit.
// Tracks ROB occupancy and retires entries strictly in program order. Register
// results are written to the register file; stores go to memory through a
// ready/valid handshake.
// Optional feature: define RB_COMMIT_STALL_CNT_EN to add the 16-bit stall_count output.
module rb_commit_controller #(
    parameter int WORD_SIZE = 32,
    parameter int RB_SIZE   = 8,
    parameter int RB_INDEX  = 3,
    parameter int REG_INDEX = 5
) (
    input  logic                         clk,
    input  logic                         reset,
    input  logic [WORD_SIZE*RB_SIZE-1:0] CDB_data_data,
    input  logic [RB_SIZE-1:0]           CDB_data_valid,
    input  logic [RB_SIZE*WORD_SIZE-1:0] CDB_data_addr,
    input  logic                         alloc_req,
    input  logic [REG_INDEX-1:0]         alloc_dest,
    input  logic                         alloc_is_store,
    output logic [RB_INDEX-1:0]          alloc_index,
    output logic                         rb_full,
    output logic                         rb_empty,
    output logic                         rf_we,
    output logic [REG_INDEX-1:0]         rf_waddr,
    output logic [WORD_SIZE-1:0]         rf_wdata,
    output logic                         mem_we,
    output logic [WORD_SIZE-1:0]         mem_addr,
    output logic [WORD_SIZE-1:0]         mem_wdata,
    input  logic                         mem_ready,
    output logic [RB_INDEX-1:0]          commit_index
`ifdef RB_COMMIT_STALL_CNT_EN
    ,
    output logic [15:0]                  stall_count
`endif
);

    typedef enum logic {IDLE, STORE_WAIT} state_t;

    state_t                 state;
    logic [RB_INDEX-1:0]    head;
    logic [RB_INDEX-1:0]    tail;
    logic [RB_INDEX:0]      count;
    logic [RB_INDEX:0]      count_next;
    logic [RB_SIZE-1:0]     occupied;
    logic [RB_SIZE-1:0]     armed;
    logic [RB_SIZE-1:0]     is_store;
    logic [REG_INDEX-1:0]   dest [RB_SIZE];
    logic [WORD_SIZE-1:0]   entry_data [RB_SIZE];
    logic [WORD_SIZE-1:0]   entry_addr [RB_SIZE];
    logic                   head_ready;
    logic                   retire;
    logic                   alloc_ok;

    // Split the flat CDB vectors into per-entry words.
    for (genvar k = 0; k < RB_SIZE; k++) begin : g_unpack
        assign entry_data[k] = CDB_data_data[k*WORD_SIZE +: WORD_SIZE];
        assign entry_addr[k] = CDB_data_addr[k*WORD_SIZE +: WORD_SIZE];
    end

    assign alloc_index = tail;
    assign alloc_ok    = alloc_req && !rb_full;
    // A leftover valid=1 from a previous occupant is ignored until a valid=0 is seen.
    assign head_ready  = occupied[head] && armed[head] && CDB_data_valid[head];
    assign retire      = ((state == IDLE) && head_ready && !is_store[head]) ||
                         ((state == STORE_WAIT) && mem_ready);

    // Occupancy count; simultaneous alloc and retire cancel out.
    always_comb begin
        count_next = count;
        case ({alloc_ok, retire})
            2'b10:   count_next = count + (RB_INDEX+1)'(1);
            2'b01:   count_next = count - (RB_INDEX+1)'(1);
            default: count_next = count;
        endcase
    end

    // Commit FSM, pointers, per-entry state and registered outputs.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state        <= IDLE;
            head         <= '0;
            tail         <= '0;
            count        <= '0;
            occupied     <= '0;
            armed        <= '0;
            is_store     <= '0;
            for (int unsigned i = 0; i < RB_SIZE; i++) dest[i] <= '0;
            rb_full      <= 1'b0;
            rb_empty     <= 1'b1;
            rf_we        <= 1'b0;
            rf_waddr     <= '0;
            rf_wdata     <= '0;
            mem_we       <= 1'b0;
            mem_addr     <= '0;
            mem_wdata    <= '0;
            commit_index <= '0;
        end else begin
            rf_we <= 1'b0;
            armed <= armed | (occupied & ~CDB_data_valid);

            case (state)
                IDLE: begin
                    if (head_ready) begin
                        commit_index <= head;
                        if (is_store[head]) begin
                            mem_we    <= 1'b1;
                            mem_addr  <= entry_addr[head];
                            mem_wdata <= entry_data[head];
                            state     <= STORE_WAIT;
                        end else begin
                            rf_we    <= 1'b1;
                            rf_waddr <= dest[head];
                            rf_wdata <= entry_data[head];
                        end
                    end
                end
                STORE_WAIT: begin
                    if (mem_ready) begin
                        mem_we <= 1'b0;
                        state  <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase

            if (retire) begin
                occupied[head] <= 1'b0;
                head           <= head + RB_INDEX'(1);
            end

            // Written after arming so a fresh allocation always starts disarmed.
            if (alloc_ok) begin
                occupied[tail] <= 1'b1;
                armed[tail]    <= 1'b0;
                is_store[tail] <= alloc_is_store;
                dest[tail]     <= alloc_dest;
                tail           <= tail + RB_INDEX'(1);
            end

            count    <= count_next;
            rb_full  <= (count_next == (RB_INDEX+1)'(RB_SIZE));
            rb_empty <= (count_next == '0);
        end
    end

`ifdef RB_COMMIT_STALL_CNT_EN
    // Saturating count of cycles where the ROB holds entries but the head makes no progress.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            stall_count <= '0;
        end else if (!rb_empty && (state == IDLE) && !head_ready && (stall_count != '1)) begin
            stall_count <= stall_count + 16'd1;
        end
    end
`endif

endmodule
